// File: rtl/io_output_serializer.sv
// -----------------------------------------------------------------------------
// io_output_serializer
//
// Parallel-to-serial output register for the periphery I/O path. A wide word
// (OUTPUT_REG_L bits) is accepted on the load side and emitted as
// N = OUTPUT_REG_L / OUTPUT_DATA_L narrow chunks, most significant chunk
// first. A receiver that shifts each chunk in toward its MSB rebuilds the
// word bit-exact.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid & ready are both high.
//   valid never drops before its transfer. While the consumer holds
//   out_ready low, out_data / out_last stay stable. load_ready depends
//   combinationally on out_ready, so out_ready must not be derived from
//   load_ready on the consumer side.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous reset, asserted when rst == RESET_STATE (low)
//   load_valid  a wide word is offered on load_data
//   load_ready  a word can be accepted this cycle
//   load_data   word to serialize (sampled only on a load handshake)
//   out_valid   out_data holds a valid chunk
//   out_ready   consumer accepts the chunk this cycle
//   out_data    current chunk (0 when out_valid is low)
//   out_last    current chunk is the final one of the word
//   shift_en    out_valid & out_ready, feeds the receiver's shift enable
//   busy        high while a word is being sent (mirrors the FSM state)
//   done        registered one-cycle pulse after the final chunk handshake
// -----------------------------------------------------------------------------
module io_output_serializer #(
  parameter int   OUTPUT_DATA_L = 32,
  parameter int   OUTPUT_REG_L  = 128,
  parameter logic RESET_STATE   = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [OUTPUT_REG_L-1:0]  load_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUTPUT_DATA_L-1:0] out_data,
  output logic                     out_last,
  output logic                     shift_en,
  output logic                     busy,
  output logic                     done
);

  localparam int N     = OUTPUT_REG_L / OUTPUT_DATA_L;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [OUTPUT_REG_L-1:0] sreg_q,  sreg_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic                    done_q,  done_d;

  logic                    cnt_zero;
  logic                    load_hs;
  logic                    out_hs;

  // ---------------------------------------------------------------------------
  // Outputs (Moore except load_ready, which looks at out_ready so a new word
  // can be taken in the same cycle as the final chunk -> no bubble).
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_zero   = (cnt_q == '0);
    out_valid  = (state_q == SEND);
    busy       = (state_q == SEND);
    out_last   = (state_q == SEND) && cnt_zero;
    load_ready = (state_q == IDLE) || ((state_q == SEND) && cnt_zero && out_ready);
    out_data   = '0;
    if (state_q == SEND) begin
      out_data = sreg_q[OUTPUT_REG_L-1 -: OUTPUT_DATA_L];
    end
    shift_en   = out_valid && out_ready;
    done       = done_q;
    load_hs    = load_valid && load_ready;
    out_hs     = shift_en;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_hs) begin
          sreg_d  = load_data;
          cnt_d   = CNT_LOAD;
          state_d = SEND;
        end
      end

      SEND: begin
        if (out_hs) begin
          if (!cnt_zero) begin
            // Move the next chunk to the top; zero-fill keeps the register
            // free of stale data once the word has drained.
            sreg_d = {sreg_q[OUTPUT_REG_L-OUTPUT_DATA_L-1:0], {OUTPUT_DATA_L{1'b0}}};
            cnt_d  = cnt_q - 1'b1;
          end else begin
            done_d = 1'b1;
            if (load_hs) begin
              // Back-to-back reload: stay in SEND with the fresh word.
              sreg_d  = load_data;
              cnt_d   = CNT_LOAD;
              state_d = SEND;
            end else begin
              sreg_d  = '0;
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET_STATE) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule
